ex_mem_skid_stage: RTL

// - Parametrised EX->MEM pipeline stage with a valid/ready handshake, a 2-entry (main + skid) buffer and flush.
// - Sits between the ALU (EX) and the data-memory access (MEM) stage.
// - Lets MEM back-pressure EX (multi-cycle memory) without losing an in-flight result.
// - Flush kills wrong-path instructions.
// - Provides a saturating stall-cycle counter for performance monitoring.

---
 rtl/ex_mem_skid_stage_pkg.sv | 28 ++
 rtl/ex_mem_skid_stage_if.sv | 43 ++++
 rtl/ex_mem_skid_stage_pipe_skid_buf.sv | 72 +++++++
 rtl/ex_mem_skid_stage.sv | 58 +++++
 4 files changed

// File: rtl/ex_mem_skid_stage_pkg.sv
// Shared EX/MEM types: control bundle, default-width payload, payload width helper.
package ex_mem_pkg;

    localparam int XLEN_DEF   = 64;
    localparam int REG_AW_DEF = 5;

    typedef struct packed {
        logic memread;
        logic memwrite;
        logic memtoreg;
        logic regwrite;
    } ex_mem_ctrl_t;

    localparam int CTRL_W = $bits(ex_mem_ctrl_t);

    typedef struct packed {
        logic [XLEN_DEF-1:0]   aluout;
        logic [XLEN_DEF-1:0]   readdata2;
        logic [REG_AW_DEF-1:0] writeregister;
        ex_mem_ctrl_t          ctrl;
    } ex_mem_payload_t;

    // Packed payload width for a given datapath / register-address width.
    function automatic int payload_w(input int xlen, input int aw);
        return 2 * xlen + aw + CTRL_W;
    endfunction

endpackage

// File: rtl/ex_mem_skid_stage_if.sv
// EX->MEM bus: producer handshake + payload, consumer handshake + registered outputs.
interface ex_mem_if #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   aluout;
    logic [XLEN-1:0]   readdata2;
    logic [REG_AW-1:0] writeregister;
    logic              memread;
    logic              memwrite;
    logic              memtoreg;
    logic              regwrite;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   aluout_out;
    logic [XLEN-1:0]   readdata2_out;
    logic [REG_AW-1:0] writeregister_out;
    logic              memread_out;
    logic              memwrite_out;
    logic              memtoreg_out;
    logic              regwrite_out;
    logic [CNT_W-1:0]  stall_cnt;

    // Environment side (EX producer, MEM consumer, flush source).
    modport master (
        output flush, in_valid, aluout, readdata2, writeregister,
               memread, memwrite, memtoreg, regwrite, out_ready,
        input  in_ready, out_valid, aluout_out, readdata2_out, writeregister_out,
               memread_out, memwrite_out, memtoreg_out, regwrite_out, stall_cnt
    );

    // Pipeline-stage side.
    modport slave (
        input  flush, in_valid, aluout, readdata2, writeregister,
               memread, memwrite, memtoreg, regwrite, out_ready,
        output in_ready, out_valid, aluout_out, readdata2_out, writeregister_out,
               memread_out, memwrite_out, memtoreg_out, regwrite_out, stall_cnt
    );
endinterface

// File: rtl/ex_mem_skid_stage_pipe_skid_buf.sv
// Generic 2-entry (main + skid) valid/ready buffer with flush on a packed payload.
// in_ready depends on state only, so out_ready never reaches in_ready combinationally.
module pipe_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);
    logic         main_v_q, main_v_d;
    logic         skid_v_q, skid_v_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         accept, pop;

    assign in_ready_o  = !skid_v_q;
    assign out_valid_o = main_v_q;
    assign out_data_o  = main_q;
    assign accept      = in_valid_i && !skid_v_q;
    assign pop         = main_v_q && out_ready_i;

    // Next-state: flush wins, then pop (skid refills main first), then plain accept.
    always_comb begin
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        main_d   = main_q;
        skid_d   = skid_q;
        if (flush_i) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (pop) begin
            if (skid_v_q) begin
                main_d   = skid_q;
                main_v_d = 1'b1;
                skid_v_d = accept;
                if (accept) skid_d = in_data_i;
            end else begin
                main_v_d = accept;
                if (accept) main_d = in_data_i;
            end
        end else if (accept) begin
            if (main_v_q) begin
                skid_d   = in_data_i;
                skid_v_d = 1'b1;
            end else begin
                main_d   = in_data_i;
                main_v_d = 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
        end else begin
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
        end
    end
endmodule

// File: rtl/ex_mem_skid_stage.sv
// EX->MEM pipeline stage: skid buffer, bubble gating of controls, saturating stall counter.
module ex_mem_skid_stage
    import ex_mem_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic   clk,
    input  logic   rst_n,
    ex_mem_if.slave bus
);
    localparam int W = payload_w(XLEN, REG_AW);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [W-1:0]     in_pl, out_pl;
    logic             out_valid;
    ex_mem_ctrl_t     ctrl_raw;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    assign in_pl = {bus.aluout, bus.readdata2, bus.writeregister,
                    bus.memread, bus.memwrite, bus.memtoreg, bus.regwrite};

    pipe_skid_buf #(.W(W)) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (bus.flush),
        .in_valid_i (bus.in_valid),
        .in_ready_o (bus.in_ready),
        .in_data_i  (in_pl),
        .out_valid_o(out_valid),
        .out_ready_i(bus.out_ready),
        .out_data_o (out_pl)
    );

    assign {bus.aluout_out, bus.readdata2_out, bus.writeregister_out, ctrl_raw} = out_pl;
    assign bus.out_valid = out_valid;

    // Bubbles (invalid or flushed main slot) must never write memory or the register file.
    assign bus.memread_out  = ctrl_raw.memread  & out_valid;
    assign bus.memwrite_out = ctrl_raw.memwrite & out_valid;
    assign bus.memtoreg_out = ctrl_raw.memtoreg & out_valid;
    assign bus.regwrite_out = ctrl_raw.regwrite & out_valid;
    assign bus.stall_cnt    = stall_cnt_q;

    // Count cycles MEM holds off a valid entry; saturate rather than wrap.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !bus.out_ready && stall_cnt_q != CNT_MAX)
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    // Stall counter register; only reset clears it, flush does not.
    always_ff @(posedge clk) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end
endmodule
